// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch control unit: FSM state codes and default
// debounce timing. Optional build macro: STOPWATCH_CU_RUN_CLEAR_EN (see stopwatch_cu).
package stopwatch_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_STOP  = 2'b00;
    localparam state_t ST_RUN   = 2'b01;
    localparam state_t ST_CLEAR = 2'b10;

    localparam int SAMPLE_DIV_DEF = 100_000;
    localparam int DB_DEPTH_DEF   = 8;

endpackage

// File: rtl/btn_debounce.sv
// One push-button conditioner: 2-FF synchronizer, sampled shift register with
// all-ones/all-zeros hysteresis, and a one-cycle rising-edge press pulse.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DB_DEPTH = DB_DEPTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_btn,
    output logic o_pulse
);

    logic [1:0]          sync_q;
    logic [DB_DEPTH-1:0] shift_q, shift_d;
    logic                level_q, level_d;
    logic                level_dly_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            shift_q     <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], i_btn};
            shift_q     <= shift_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
        end
    end

    // Level only moves on a full run of identical samples; mixed history holds it.
    always_comb begin
        shift_d = shift_q;
        if (i_tick) begin
            shift_d = {shift_q[DB_DEPTH-2:0], sync_q[1]};
        end
        level_d = level_q;
        if (&shift_q) begin
            level_d = 1'b1;
        end else if (~|shift_q) begin
            level_d = 1'b0;
        end
    end

    assign o_pulse = level_q & ~level_dly_q;

endmodule

// File: rtl/stopwatch_cu.sv
// Stopwatch control unit: debounced RUN/CLEAR buttons drive a STOP/RUN/CLEAR Moore FSM.
// Define STOPWATCH_CU_RUN_CLEAR_EN to let CLEAR also stop a running stopwatch.
module stopwatch_cu
    import stopwatch_pkg::*;
#(
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
    parameter int DB_DEPTH   = DB_DEPTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_run,
    input  logic i_btn_clear,
    output logic o_run_stop,
    output logic o_clear
);

    localparam int             CNT_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLE_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sample_tick;
    logic             run_pulse, clr_pulse;
    state_t           state_q, state_d;

    // Shared prescaler: one sample tick every SAMPLE_DIV cycles for both buttons.
    assign sample_tick = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (sample_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    btn_debounce #(.DB_DEPTH(DB_DEPTH)) u_db_run (
        .clk    (clk),
        .rst    (rst),
        .i_tick (sample_tick),
        .i_btn  (i_btn_run),
        .o_pulse(run_pulse)
    );

    btn_debounce #(.DB_DEPTH(DB_DEPTH)) u_db_clear (
        .clk    (clk),
        .rst    (rst),
        .i_tick (sample_tick),
        .i_btn  (i_btn_clear),
        .o_pulse(clr_pulse)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_STOP;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear has priority when stopped; run has priority when running.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: begin
                if (clr_pulse) begin
                    state_d = ST_CLEAR;
                end else if (run_pulse) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (run_pulse) begin
                    state_d = ST_STOP;
`ifdef STOPWATCH_CU_RUN_CLEAR_EN
                end else if (clr_pulse) begin
                    state_d = ST_CLEAR;
`endif
                end
            end
            ST_CLEAR: state_d = ST_STOP;
            default:  state_d = ST_STOP;
        endcase
    end

    always_comb begin
        o_run_stop = (state_q == ST_RUN);
        o_clear    = (state_q == ST_CLEAR);
    end

endmodule

// File: tb/tb_stopwatch_cu.sv
// Bench for stopwatch_cu at SAMPLE_DIV=4, DB_DEPTH=4: table of button windows
// with expected outcomes queued on drive and compared after each window.
module tb_stopwatch_cu;

    logic clk = 1'b0;
    logic rst;
    logic btn_run;
    logic btn_clear;
    logic run_stop;
    logic clr;

    always #5 clk = ~clk;

    stopwatch_cu #(.SAMPLE_DIV(4), .DB_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_btn_run  (btn_run),
        .i_btn_clear(btn_clear),
        .o_run_stop (run_stop),
        .o_clear    (clr)
    );

    typedef struct {
        string name;
        bit    run;
        bit    clr;
        bit    bounce;
        int    cycles;
        bit    exp_rs;
        int    exp_clr;
        int    exp_edges;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic void add(input string n, input bit r, input bit c, input bit b,
                                input int cy, input bit ers, input int ec, input int ee);
        vec_t v;
        v.name = n; v.run = r; v.clr = c; v.bounce = b; v.cycles = cy;
        v.exp_rs = ers; v.exp_clr = ec; v.exp_edges = ee;
        vecs.push_back(v);
    endfunction

    task automatic apply(input vec_t v);
        int   clr_pulses = 0;
        int   clr_hi = 0;
        int   edges = 0;
        int   first = -1;
        logic prev_rs = run_stop;
        logic prev_clr = clr;
        vec_t e;
        sb.push_back(v);
        btn_run   = v.run;
        btn_clear = v.clr;
        for (int c = 0; c < v.cycles; c++) begin
            if (v.bounce) btn_run = ((c / 3) % 2 == 0);
            @(posedge clk); #1;
            if (clr) clr_hi++;
            if (clr && !prev_clr) begin
                clr_pulses++;
                if (first < 0) first = c + 1;
            end
            if (run_stop !== prev_rs) begin
                edges++;
                if (first < 0) first = c + 1;
            end
            prev_rs  = run_stop;
            prev_clr = clr;
        end
        if (v.bounce) btn_run = 1'b0;
        e = sb.pop_front();
        check({e.name, ".run_stop"}, int'(run_stop), int'(e.exp_rs));
        check({e.name, ".clr_pulses"}, clr_pulses, e.exp_clr);
        check({e.name, ".clr_cycles"}, clr_hi, e.exp_clr);
        check({e.name, ".rs_edges"}, edges, e.exp_edges);
        if (e.exp_clr > 0 || e.exp_edges > 0) begin
            n_cmp++;
            if (first < 1 || first > 24) begin
                n_bad++;
                $display("FAIL %s.latency: got %0d cycles, required 1..24", e.name, first);
            end
        end
    endtask

    initial begin
        int hi;
        add("rst_held",  1, 1, 0, 40, 0, 1, 0);
        add("idle0",     0, 0, 0, 40, 0, 0, 0);
        add("run_on",    1, 0, 0, 40, 1, 0, 1);
        add("idle1",     0, 0, 0, 40, 1, 0, 0);
        add("run_off",   1, 0, 0, 40, 0, 0, 1);
        add("idle2",     0, 0, 0, 40, 0, 0, 0);
        add("bounce",    0, 0, 1, 60, 0, 0, 0);
        add("idle3",     0, 0, 0, 40, 0, 0, 0);
        add("run_clean", 1, 0, 0, 40, 1, 0, 1);
        add("idle4",     0, 0, 0, 40, 1, 0, 0);
`ifdef STOPWATCH_CU_RUN_CLEAR_EN
        add("clr_in_run", 0, 1, 0, 40, 0, 1, 1);
        add("idle5",      0, 0, 0, 40, 0, 0, 0);
`else
        add("clr_in_run", 0, 1, 0, 40, 1, 0, 0);
        add("idle5",      0, 0, 0, 40, 1, 0, 0);
        add("run_stop",   1, 0, 0, 40, 0, 0, 1);
        add("idle6",      0, 0, 0, 40, 0, 0, 0);
`endif
        add("clr_stop",  0, 1, 0, 40, 0, 1, 0);
        add("idle7",     0, 0, 0, 40, 0, 0, 0);
        add("both",      1, 1, 0, 40, 0, 1, 0);
        add("idle8",     0, 0, 0, 40, 0, 0, 0);
        add("run_again", 1, 0, 0, 40, 1, 0, 1);
        add("idle9",     0, 0, 0, 40, 1, 0, 0);

        rst = 1'b1; btn_run = 1'b1; btn_clear = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("reset.run_stop", int'(run_stop), 0);
            check("reset.clear", int'(clr), 0);
        end
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Async reset while running: output must drop before the next clock edge.
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("async_rst.run_stop", int'(run_stop), 0);
        check("async_rst.clear", int'(clr), 0);
        #10;
        rst = 1'b0;
        hi = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (clr || run_stop) hi++;
        end
        check("post_rst.quiet", hi, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
